mod_vga_timing: RTL

MOD_VGA_TIMING -- requirements
Module: mod_vga_timing

---
 rtl/vga_timing_pkg.sv | 50 +++++
 rtl/mod_vga_axis_counter.sv | 46 ++++
 rtl/mod_vga_timing.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: shared VGA timing constants, NES window geometry and the
// registered output payload used by mod_vga_timing.
package vga_timing_pkg;

  // Counter width and the largest total either axis may use.
  localparam int unsigned CNT_W          = 10;
  localparam int unsigned CNT_MAX_TOTAL  = 1 << CNT_W;

  // Default 640x480@60 timing (pixel clock 25.175 MHz).
  localparam int unsigned H_ACTIVE_DEF   = 640;
  localparam int unsigned H_FRONT_DEF    = 16;
  localparam int unsigned H_SYNC_DEF     = 96;
  localparam int unsigned H_BACK_DEF     = 48;
  localparam int unsigned V_ACTIVE_DEF   = 480;
  localparam int unsigned V_FRONT_DEF    = 10;
  localparam int unsigned V_SYNC_DEF     = 2;
  localparam int unsigned V_BACK_DEF     = 33;
  localparam int unsigned H_TOTAL_DEF    = H_ACTIVE_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;
  localparam int unsigned V_TOTAL_DEF    = V_ACTIVE_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

  // NES 256x240 picture scaled 2x and centred horizontally in 640 pixels.
  localparam int unsigned NES_W          = 8;
  localparam int unsigned NES_SHIFT      = 1;
  localparam int unsigned NES_X_START    = 64;
  localparam int unsigned NES_X_END      = NES_X_START + (256 << NES_SHIFT);

  // Registered timing outputs, all describing the same (h, v).
  typedef struct packed {
    logic             hsync;
    logic             vsync;
    logic             active;
    logic [CNT_W-1:0] x;
    logic [CNT_W-1:0] y;
    logic             line_start;
    logic             frame_start;
  } vga_out_t;

  localparam vga_out_t VGA_OUT_RST = '{
    hsync: 1'b1, vsync: 1'b1, active: 1'b0, x: '0, y: '0,
    line_start: 1'b0, frame_start: 1'b0
  };

  // True when lo <= c < hi.
  function automatic logic in_window(input logic [CNT_W-1:0] c,
                                     input int unsigned lo,
                                     input int unsigned hi);
    return (32'(c) >= lo) && (32'(c) < hi);
  endfunction

endpackage

// File: rtl/mod_vga_axis_counter.sv
// mod_vga_axis_counter: one timing axis -- wrapping counter plus decode of
// the active region and the sync window for the current count.
module mod_vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int unsigned TOTAL      = H_TOTAL_DEF,
  parameter int unsigned ACTIVE     = H_ACTIVE_DEF,
  parameter int unsigned SYNC_START = H_ACTIVE_DEF + H_FRONT_DEF,
  parameter int unsigned SYNC_END   = H_ACTIVE_DEF + H_FRONT_DEF + H_SYNC_DEF
)(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] count_o,
  output logic             wrap_c,
  output logic             first_c,
  output logic             active_c,
  output logic             sync_c
);

  logic [CNT_W-1:0] count_q, count_d;

  assign wrap_c   = inc_i && (count_q == CNT_W'(TOTAL - 1));
  assign first_c  = (count_q == '0);
  assign active_c = (32'(count_q) < ACTIVE);
  assign sync_c   = in_window(count_q, SYNC_START, SYNC_END);
  assign count_o  = count_q;

  // Next count: advance on inc, wrapping TOTAL-1 back to zero.
  always_comb begin
    count_d = count_q;
    if (inc_i) begin
      count_d = wrap_c ? '0 : count_q + CNT_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/mod_vga_timing.sv
// mod_vga_timing: VGA sync/position generator. Outputs are registered one
// cycle after the counter state and always describe a single (h, v).
// Optional macro VGA_TIMING_NES_WINDOW_EN adds the 2x-scaled 256x240 window.
module mod_vga_timing
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned H_FRONT  = H_FRONT_DEF,
  parameter int unsigned H_SYNC   = H_SYNC_DEF,
  parameter int unsigned H_BACK   = H_BACK_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
  parameter int unsigned V_FRONT  = V_FRONT_DEF,
  parameter int unsigned V_SYNC   = V_SYNC_DEF,
  parameter int unsigned V_BACK   = V_BACK_DEF
)(
  input  logic             in_clk_25_175_mhz,
  input  logic             in_reset,
  input  logic             in_enable,
  output logic             out_hsync,
  output logic             out_vsync,
  output logic             out_active,
  output logic [CNT_W-1:0] out_x,
  output logic [CNT_W-1:0] out_y,
  output logic             out_line_start,
  output logic             out_frame_start,
  output logic             out_nes_window,
  output logic [NES_W-1:0] out_nes_x,
  output logic [NES_W-1:0] out_nes_y
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  // Timing that does not fit the 10-bit counters is rejected at elaboration.
  if (H_TOTAL > CNT_MAX_TOTAL || V_TOTAL > CNT_MAX_TOTAL) begin : g_total_check
    $error("mod_vga_timing: H_TOTAL/V_TOTAL exceed the 10-bit counter range");
  end

  logic [CNT_W-1:0] h_cnt, v_cnt;
  logic             h_wrap_c, h_first_c, h_active_c, h_sync_c;
  logic             v_wrap_unused, v_first_c, v_active_c, v_sync_c;
  vga_out_t         out_q, out_d;

  mod_vga_axis_counter #(
    .TOTAL      (H_TOTAL),
    .ACTIVE     (H_ACTIVE),
    .SYNC_START (H_ACTIVE + H_FRONT),
    .SYNC_END   (H_ACTIVE + H_FRONT + H_SYNC)
  ) u_h_axis (
    .clk_i    (in_clk_25_175_mhz),
    .rst_i    (in_reset),
    .inc_i    (in_enable),
    .count_o  (h_cnt),
    .wrap_c   (h_wrap_c),
    .first_c  (h_first_c),
    .active_c (h_active_c),
    .sync_c   (h_sync_c)
  );

  // The vertical axis steps once per completed line.
  mod_vga_axis_counter #(
    .TOTAL      (V_TOTAL),
    .ACTIVE     (V_ACTIVE),
    .SYNC_START (V_ACTIVE + V_FRONT),
    .SYNC_END   (V_ACTIVE + V_FRONT + V_SYNC)
  ) u_v_axis (
    .clk_i    (in_clk_25_175_mhz),
    .rst_i    (in_reset),
    .inc_i    (h_wrap_c),
    .count_o  (v_cnt),
    .wrap_c   (v_wrap_unused),
    .first_c  (v_first_c),
    .active_c (v_active_c),
    .sync_c   (v_sync_c)
  );

  // Output decode: load on enable, otherwise hold with pulses forced low.
  always_comb begin
    out_d             = out_q;
    out_d.line_start  = 1'b0;
    out_d.frame_start = 1'b0;
    if (in_enable) begin
      out_d.hsync       = ~h_sync_c;
      out_d.vsync       = ~v_sync_c;
      out_d.active      = h_active_c & v_active_c;
      out_d.x           = h_cnt;
      out_d.y           = v_cnt;
      out_d.line_start  = h_first_c;
      out_d.frame_start = h_first_c & v_first_c;
    end
  end

  // Output register.
  always_ff @(posedge in_clk_25_175_mhz or posedge in_reset) begin
    if (in_reset) begin
      out_q <= VGA_OUT_RST;
    end else begin
      out_q <= out_d;
    end
  end

  assign out_hsync       = out_q.hsync;
  assign out_vsync       = out_q.vsync;
  assign out_active      = out_q.active;
  assign out_x           = out_q.x;
  assign out_y           = out_q.y;
  assign out_line_start  = out_q.line_start;
  assign out_frame_start = out_q.frame_start;

`ifdef VGA_TIMING_NES_WINDOW_EN
  logic             nes_win_c;
  logic [CNT_W-1:0] nes_dx_c;
  logic [NES_W-1:0] nes_x_c, nes_y_c;
  logic             nes_win_q;
  logic [NES_W-1:0] nes_x_q, nes_y_q;

  assign nes_win_c = h_active_c & v_active_c & in_window(h_cnt, NES_X_START, NES_X_END);
  assign nes_dx_c  = h_cnt - CNT_W'(NES_X_START);
  assign nes_x_c   = nes_win_c ? NES_W'(nes_dx_c >> NES_SHIFT) : '0;
  assign nes_y_c   = nes_win_c ? NES_W'(v_cnt >> NES_SHIFT) : '0;

  // NES window registers, aligned with the main outputs.
  always_ff @(posedge in_clk_25_175_mhz or posedge in_reset) begin
    if (in_reset) begin
      nes_win_q <= 1'b0;
      nes_x_q   <= '0;
      nes_y_q   <= '0;
    end else if (in_enable) begin
      nes_win_q <= nes_win_c;
      nes_x_q   <= nes_x_c;
      nes_y_q   <= nes_y_c;
    end
  end

  assign out_nes_window = nes_win_q;
  assign out_nes_x      = nes_x_q;
  assign out_nes_y      = nes_y_q;
`else
  assign out_nes_window = 1'b0;
  assign out_nes_x      = '0;
  assign out_nes_y      = '0;
`endif

endmodule
